nova_io_pio_ctrl: RTL and testbench



---
 rtl/nova_io_pkg.sv | 61 ++++++
 rtl/nova_io_decode.sv | 29 ++
 rtl/nova_io_pio_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_nova_io_pio_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nova_io_pkg.sv
// Shared codes, sub-addresses, status bits and state type for the Nova PIO sequencer.
// NOVA_IO_SKIP_EN adds the SKRD/SKWAIT states used by SKP instructions.
package nova_io_pkg;

    localparam logic [0:2] XFER_NIO = 3'b000;
    localparam logic [0:2] XFER_DIA = 3'b001;
    localparam logic [0:2] XFER_DOA = 3'b010;
    localparam logic [0:2] XFER_DIB = 3'b011;
    localparam logic [0:2] XFER_DOB = 3'b100;
    localparam logic [0:2] XFER_DIC = 3'b101;
    localparam logic [0:2] XFER_DOC = 3'b110;
    localparam logic [0:2] XFER_SKP = 3'b111;

    localparam logic [0:1] CTRL_NONE = 2'b00;
    localparam logic [0:1] CTRL_S    = 2'b01;
    localparam logic [0:1] CTRL_C    = 2'b10;
    localparam logic [0:1] CTRL_P    = 2'b11;

    localparam logic [0:1] SKP_BN = 2'b00;
    localparam logic [0:1] SKP_BZ = 2'b01;
    localparam logic [0:1] SKP_DN = 2'b10;
    localparam logic [0:1] SKP_DZ = 2'b11;

    localparam logic [0:1] SUB_CTRL = 2'b00;
    localparam logic [0:1] SUB_A    = 2'b01;
    localparam logic [0:1] SUB_B    = 2'b10;
    localparam logic [0:1] SUB_C    = 2'b11;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;

    localparam logic [0:5] NOVA_CPU_DEV = 6'o77;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XFER,
        ST_XWAIT,
        ST_CTRL,
`ifdef NOVA_IO_SKIP_EN
        ST_SKRD,
        ST_SKWAIT,
`endif
        ST_DONE
    } state_t;

    function automatic logic skip_result(input logic [0:1] cond, input logic [0:15] status);
        logic busy;
        logic done;
        logic result;
        busy = status[STAT_BUSY_BIT];
        done = status[STAT_DONE_BIT];
        case (cond)
            SKP_BN:  result = busy;
            SKP_BZ:  result = !busy;
            SKP_DN:  result = done;
            default: result = !done;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/nova_io_decode.sv
// Classifies an I/O transfer code into read / write / skip and the data sub-address.
module nova_io_decode
    import nova_io_pkg::*;
(
    input  logic [0:2] xfer,
    output logic       is_read,
    output logic       is_write,
    output logic       is_skip,
    output logic [0:1] sub
);

    always_comb begin
        is_read  = 1'b0;
        is_write = 1'b0;
        is_skip  = 1'b0;
        sub      = SUB_CTRL;
        case (xfer)
            XFER_DIA: begin is_read  = 1'b1; sub = SUB_A; end
            XFER_DOA: begin is_write = 1'b1; sub = SUB_A; end
            XFER_DIB: begin is_read  = 1'b1; sub = SUB_B; end
            XFER_DOB: begin is_write = 1'b1; sub = SUB_B; end
            XFER_DIC: begin is_read  = 1'b1; sub = SUB_C; end
            XFER_DOC: begin is_write = 1'b1; sub = SUB_C; end
            XFER_SKP: is_skip = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: rtl/nova_io_pio_ctrl.sv
// Programmed-I/O sequencer: turns one Nova I/O instruction into device-bus strobes.
// SKP bus handling is present only when NOVA_IO_SKIP_EN is defined.
module nova_io_pio_ctrl
    import nova_io_pkg::*;
#(
    parameter logic [0:5] CPU_DEV = NOVA_CPU_DEV
) (
    input  logic        pclk,
    input  logic        bs_rst,
    input  logic        io_req,
    input  logic [0:2]  io_xfer,
    input  logic [0:1]  io_ctrl,
    input  logic [0:5]  io_dev,
    input  logic [0:15] io_wdata,
    output logic        io_ack,
    output logic [0:15] io_rdata,
    output logic        io_skip,
    output logic        io_busy,
    output logic        bs_stb,
    output logic        bs_we,
    output logic [0:7]  bs_adr,
    output logic [0:15] bs_din,
    input  logic [0:15] bs_dout
);

    state_t state_reg, state_next;

    logic       dec_read, dec_write, dec_skip;
    logic [0:1] dec_sub;
    logic       accept, to_cpu;

    logic        read_reg, read_next;
    logic [0:1]  sub_reg, sub_next;
    logic [0:1]  ctrl_reg, ctrl_next;
    logic [0:5]  dev_reg, dev_next;
    logic [0:15] wdata_reg, wdata_next;

    logic        stb_reg, stb_next, we_reg, we_next;
    logic        ack_reg, ack_next, busy_reg, busy_next;
    logic [0:7]  adr_reg, adr_next;
    logic [0:15] din_reg, din_next, rdata_reg;

    nova_io_decode u_decode (
        .xfer     (io_xfer),
        .is_read  (dec_read),
        .is_write (dec_write),
        .is_skip  (dec_skip),
        .sub      (dec_sub)
    );

    assign accept = (state_reg == ST_IDLE) && io_req;
    assign to_cpu = (io_dev == CPU_DEV);

    // Output decode looks at next-cycle values so the bus sees registered signals.
    assign read_next  = accept ? dec_read : read_reg;
    assign sub_next   = accept ? dec_sub  : sub_reg;
    assign ctrl_next  = accept ? io_ctrl  : ctrl_reg;
    assign dev_next   = accept ? io_dev   : dev_reg;
    assign wdata_next = accept ? io_wdata : wdata_reg;

    always_ff @(posedge pclk) begin
        if (bs_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (io_req) begin
                    if (to_cpu) begin
                        state_next = ST_DONE;
                    end else if (dec_read || dec_write) begin
                        state_next = ST_XFER;
                    end else if (dec_skip) begin
`ifdef NOVA_IO_SKIP_EN
                        state_next = ST_SKRD;
`else
                        state_next = ST_DONE;
`endif
                    end else if (io_ctrl != CTRL_NONE) begin
                        state_next = ST_CTRL;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_XFER: begin
                if (read_reg) begin
                    state_next = ST_XWAIT;
                end else begin
                    state_next = (ctrl_reg != CTRL_NONE) ? ST_CTRL : ST_DONE;
                end
            end
            ST_XWAIT:  state_next = (ctrl_reg != CTRL_NONE) ? ST_CTRL : ST_DONE;
            ST_CTRL:   state_next = ST_DONE;
`ifdef NOVA_IO_SKIP_EN
            ST_SKRD:   state_next = ST_SKWAIT;
            ST_SKWAIT: state_next = ST_DONE;
`endif
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stb_next  = 1'b0;
        we_next   = 1'b0;
        adr_next  = '0;
        din_next  = '0;
        ack_next  = 1'b0;
        busy_next = (state_next != ST_IDLE);
        case (state_next)
            ST_XFER: begin
                stb_next = 1'b1;
                we_next  = !read_next;
                adr_next = {dev_next, sub_next};
                din_next = read_next ? 16'h0000 : wdata_next;
            end
            ST_CTRL: begin
                stb_next = 1'b1;
                we_next  = 1'b1;
                adr_next = {dev_next, SUB_CTRL};
                din_next = {14'b0, ctrl_next};
            end
`ifdef NOVA_IO_SKIP_EN
            ST_SKRD: begin
                stb_next = 1'b1;
                adr_next = {dev_next, SUB_CTRL};
            end
`endif
            ST_DONE: ack_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (bs_rst) begin
            read_reg  <= 1'b0;
            sub_reg   <= '0;
            ctrl_reg  <= '0;
            dev_reg   <= '0;
            wdata_reg <= '0;
        end else begin
            read_reg  <= read_next;
            sub_reg   <= sub_next;
            ctrl_reg  <= ctrl_next;
            dev_reg   <= dev_next;
            wdata_reg <= wdata_next;
        end
    end

    always_ff @(posedge pclk) begin
        if (bs_rst) begin
            stb_reg  <= 1'b0;
            we_reg   <= 1'b0;
            adr_reg  <= '0;
            din_reg  <= '0;
            ack_reg  <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            stb_reg  <= stb_next;
            we_reg   <= we_next;
            adr_reg  <= adr_next;
            din_reg  <= din_next;
            ack_reg  <= ack_next;
            busy_reg <= busy_next;
        end
    end

    // Read data persists across instructions; only the CPU pseudo-device forces it to zero.
    always_ff @(posedge pclk) begin
        if (bs_rst) begin
            rdata_reg <= '0;
        end else if (state_reg == ST_XWAIT) begin
            rdata_reg <= bs_dout;
        end else if (accept && to_cpu) begin
            rdata_reg <= '0;
        end
    end

`ifdef NOVA_IO_SKIP_EN
    logic skip_reg;

    always_ff @(posedge pclk) begin
        if (bs_rst) begin
            skip_reg <= 1'b0;
        end else if (state_reg == ST_SKWAIT) begin
            skip_reg <= skip_result(ctrl_reg, bs_dout);
        end else begin
            skip_reg <= 1'b0;
        end
    end

    assign io_skip = skip_reg;
`else
    assign io_skip = 1'b0;
`endif

    assign io_ack   = ack_reg;
    assign io_rdata = rdata_reg;
    assign io_busy  = busy_reg;
    assign bs_stb   = stb_reg;
    assign bs_we    = we_reg;
    assign bs_adr   = adr_reg;
    assign bs_din   = din_reg;

endmodule

// File: tb/tb_nova_io_pio_ctrl.sv
// Bench for nova_io_pio_ctrl: cycle-by-cycle comparison against an instruction-level model.
`timescale 1ns/1ps
module tb_nova_io_pio_ctrl;

    localparam int NC = 4096;
`ifdef NOVA_IO_SKIP_EN
    localparam int SKP_ACK    = 3;
    localparam bit SKP_BN_EXP = 1'b1;
`else
    localparam int SKP_ACK    = 1;
    localparam bit SKP_BN_EXP = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        bs_rst = 1'b1;
    logic        io_req = 1'b0;
    logic [0:2]  io_xfer = '0;
    logic [0:1]  io_ctrl = '0;
    logic [0:5]  io_dev = '0;
    logic [0:15] io_wdata = '0;
    logic        io_ack, io_skip, io_busy, bs_stb, bs_we;
    logic [0:15] io_rdata, bs_din;
    logic [0:7]  bs_adr;
    logic [0:15] bs_dout = '0;

    nova_io_pio_ctrl dut (
        .pclk     (pclk),
        .bs_rst   (bs_rst),
        .io_req   (io_req),
        .io_xfer  (io_xfer),
        .io_ctrl  (io_ctrl),
        .io_dev   (io_dev),
        .io_wdata (io_wdata),
        .io_ack   (io_ack),
        .io_rdata (io_rdata),
        .io_skip  (io_skip),
        .io_busy  (io_busy),
        .bs_stb   (bs_stb),
        .bs_we    (bs_we),
        .bs_adr   (bs_adr),
        .bs_din   (bs_din),
        .bs_dout  (bs_dout)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Expected outputs per cycle; untouched cycles are an idle bus.
    bit        e_stb[NC], e_we[NC], e_ack[NC], e_busy[NC], e_skip[NC];
    bit [0:7]  e_adr[NC];
    bit [0:15] e_din[NC], e_rdata[NC];

    // Reference device state (driven by instructions) and bus-side device state (driven by strobes).
    bit [0:15] ref_data[64][4];
    bit        ref_busy[64], ref_done[64];
    bit [0:15] ref_rdata;
    bit [0:15] bus_data[64][4];
    bit        bus_busy[64], bus_done[64];

    logic       obs_stb[8], obs_we[8], obs_ack[8], obs_skip[8], obs_busy[8];
    logic [0:7] obs_adr[8];
    logic [0:15] obs_din[8], obs_rdata[8];

    function automatic bit [1:0] ctrl_effect(input logic [0:1] c, input bit [1:0] cur);
        case (c)
            2'b01:   return 2'b10;
            2'b10:   return 2'b00;
            2'b11:   return 2'b01;
            default: return cur;
        endcase
    endfunction

    // Device side: reply one cycle after a read strobe, garbage otherwise.
    bit        resp_valid;
    bit [0:15] resp_val;
    always @(negedge pclk) begin
        resp_valid = 1'b0;
        if (bs_stb === 1'b1) begin
            if (bs_we === 1'b1) begin
                if (bs_adr[6:7] == 2'b00)
                    {bus_busy[bs_adr[0:5]], bus_done[bs_adr[0:5]]} =
                        ctrl_effect(bs_din[14:15], {bus_busy[bs_adr[0:5]], bus_done[bs_adr[0:5]]});
                else
                    bus_data[bs_adr[0:5]][bs_adr[6:7]] = bs_din;
            end else begin
                resp_valid = 1'b1;
                if (bs_adr[6:7] == 2'b00)
                    resp_val = {bus_busy[bs_adr[0:5]], bus_done[bs_adr[0:5]], 14'b0};
                else
                    resp_val = bus_data[bs_adr[0:5]][bs_adr[6:7]];
            end
        end
    end

    always @(posedge pclk) begin
        #1;
        bs_dout = resp_valid ? resp_val : 16'($urandom);
    end

    always @(negedge pclk) begin
        if (cyc >= 1 && cyc < NC) begin
            checks++;
            if (bs_stb !== e_stb[cyc] || bs_we !== e_we[cyc] || bs_adr !== e_adr[cyc] ||
                bs_din !== e_din[cyc] || io_ack !== e_ack[cyc] || io_busy !== e_busy[cyc] ||
                io_skip !== e_skip[cyc] || (e_ack[cyc] && io_rdata !== e_rdata[cyc])) begin
                errors++;
                $display("FAIL cycle %0d: got stb=%b we=%b adr=%h din=%h ack=%b busy=%b skip=%b rdata=%h expected stb=%b we=%b adr=%h din=%h ack=%b busy=%b skip=%b rdata=%h",
                         cyc, bs_stb, bs_we, bs_adr, bs_din, io_ack, io_busy, io_skip, io_rdata,
                         e_stb[cyc], e_we[cyc], e_adr[cyc], e_din[cyc], e_ack[cyc], e_busy[cyc],
                         e_skip[cyc], e_ack[cyc] ? e_rdata[cyc] : io_rdata);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic put_stb(input int t, input bit we, input bit [0:7] adr, input bit [0:15] din);
        e_stb[t] = 1'b1;
        e_we[t]  = we;
        e_adr[t] = adr;
        e_din[t] = din;
    endtask

    // Issues one instruction in the current (idle) cycle and returns at the negedge of its ack cycle.
    task automatic run_txn(input logic [0:2] x, input logic [0:1] c, input logic [0:5] d,
                           input logic [0:15] w, input bit rst_in_wait, output int L);
        int k, t;
        bit rd, wr, sk, sk_res;
        bit [0:1] sub;
        k  = cyc;
        t  = k;
        rd = (x == 3'b001 || x == 3'b011 || x == 3'b101);
        wr = (x == 3'b010 || x == 3'b100 || x == 3'b110);
        sk = (x == 3'b111);
        sub = 2'((32'(x) + 1) / 2);
        sk_res = 1'b0;
        if (d == 6'o77) begin
            ref_rdata = 16'h0000;
        end else if (rd || wr) begin
            t++;
            put_stb(t, wr, {d, sub}, wr ? w : 16'h0000);
            if (wr) ref_data[d][sub] = w;
            if (rd) begin
                t++;
                ref_rdata = ref_data[d][sub];
            end
            if (c != 2'b00) begin
                t++;
                put_stb(t, 1'b1, {d, 2'b00}, {14'b0, c});
                {ref_busy[d], ref_done[d]} = ctrl_effect(c, {ref_busy[d], ref_done[d]});
            end
        end else if (sk) begin
`ifdef NOVA_IO_SKIP_EN
            t++;
            put_stb(t, 1'b0, {d, 2'b00}, 16'h0000);
            t++;
            case (c)
                2'b00:   sk_res = ref_busy[d];
                2'b01:   sk_res = !ref_busy[d];
                2'b10:   sk_res = ref_done[d];
                default: sk_res = !ref_done[d];
            endcase
`endif
        end else if (c != 2'b00) begin
            t++;
            put_stb(t, 1'b1, {d, 2'b00}, {14'b0, c});
            {ref_busy[d], ref_done[d]} = ctrl_effect(c, {ref_busy[d], ref_done[d]});
        end
        t++;
        e_ack[t]   = 1'b1;
        e_skip[t]  = sk_res;
        e_rdata[t] = ref_rdata;
        for (int i = k + 1; i <= t; i++) e_busy[i] = 1'b1;
        L = t - k;
        if (rst_in_wait) begin
            for (int i = k + 3; i <= t; i++) begin
                e_ack[i] = 1'b0; e_busy[i] = 1'b0; e_skip[i] = 1'b0;
                e_stb[i] = 1'b0; e_we[i] = 1'b0; e_adr[i] = '0; e_din[i] = '0;
            end
            ref_rdata = 16'h0000;
            L = 3;
        end
        for (int i = 0; i < 8; i++) begin
            obs_stb[i] = 0; obs_we[i] = 0; obs_ack[i] = 0; obs_skip[i] = 0; obs_busy[i] = 0;
            obs_adr[i] = '0; obs_din[i] = '0; obs_rdata[i] = '0;
        end
        io_req = 1'b1; io_xfer = x; io_ctrl = c; io_dev = d; io_wdata = w;
        for (int i = 1; i <= L; i++) begin
            @(negedge pclk);
            obs_stb[i] = bs_stb; obs_we[i] = bs_we; obs_adr[i] = bs_adr; obs_din[i] = bs_din;
            obs_ack[i] = io_ack; obs_skip[i] = io_skip; obs_rdata[i] = io_rdata; obs_busy[i] = io_busy;
            if (rst_in_wait && i == 2) bs_rst = 1'b1;
            if (rst_in_wait && i == 3) bs_rst = 1'b0;
            if (i == L) begin
                io_req = 1'b0;
            end else begin
                io_req = 1'($urandom); io_xfer = 3'($urandom); io_ctrl = 2'($urandom);
                io_dev = 6'($urandom); io_wdata = 16'($urandom);
            end
        end
        $display("txn cyc=%0d xfer=%b ctrl=%b dev=%o wdata=%h lat=%0d rdata=%h skip=%b",
                 k, x, c, d, w, L, obs_rdata[L], obs_skip[L]);
    endtask

    initial begin
        int L;
        logic [0:2]  x;
        logic [0:1]  c;
        logic [0:5]  d;
        logic [0:15] w;
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 4; j++) begin
                ref_data[i][j] = 16'($urandom);
                bus_data[i][j] = ref_data[i][j];
            end
        end
        ref_data[6'o12][2] = 16'hBEEF;
        bus_data[6'o12][2] = 16'hBEEF;
        ref_rdata = 16'h0000;

        bs_rst = 1'b1;
        repeat (3) @(negedge pclk);
        lit("reset_busy", 32'(io_busy), 32'd0);
        lit("reset_rdata", 32'(io_rdata), 32'd0);
        lit("reset_stb", 32'(bs_stb), 32'd0);
        bs_rst = 1'b0;
        @(negedge pclk);

        run_txn(3'b010, 2'b00, 6'o12, 16'h1234, 1'b0, L);
        lit("doa_stb", 32'(obs_stb[1]), 32'd1);
        lit("doa_we", 32'(obs_we[1]), 32'd1);
        lit("doa_adr", 32'(obs_adr[1]), 32'b00101001);
        lit("doa_din", 32'(obs_din[1]), 32'h1234);
        lit("doa_ack_n1", 32'(obs_ack[1]), 32'd0);
        lit("doa_ack_n2", 32'(obs_ack[2]), 32'd1);

        @(negedge pclk);
        run_txn(3'b011, 2'b01, 6'o12, 16'h0000, 1'b0, L);
        lit("dib_adr", 32'(obs_adr[1]), 32'b00101010);
        lit("dib_we", 32'(obs_we[1]), 32'd0);
        lit("dib_ctrl_adr", 32'(obs_adr[3]), 32'b00101000);
        lit("dib_ctrl_din", 32'(obs_din[3]), 32'h0001);
        lit("dib_ack_n4", 32'(obs_ack[4]), 32'd1);
        lit("dib_rdata", 32'(obs_rdata[4]), 32'hBEEF);

        @(negedge pclk);
        run_txn(3'b000, 2'b10, 6'o05, 16'h0000, 1'b0, L);
        lit("nioc_adr", 32'(obs_adr[1]), 32'b00010100);
        lit("nioc_din", 32'(obs_din[1]), 32'h0002);
        lit("nioc_ack_n2", 32'(obs_ack[2]), 32'd1);

        @(negedge pclk);
        run_txn(3'b111, 2'b10, 6'o05, 16'h0000, 1'b0, L);
        lit("skpdn_ack", 32'(obs_ack[SKP_ACK]), 32'd1);
        lit("skpdn_skip", 32'(obs_skip[SKP_ACK]), 32'd0);

        @(negedge pclk);
        run_txn(3'b000, 2'b01, 6'o05, 16'h0000, 1'b0, L);
        @(negedge pclk);
        run_txn(3'b111, 2'b00, 6'o05, 16'h0000, 1'b0, L);
        lit("skpbn_skip", 32'(obs_skip[SKP_ACK]), 32'(SKP_BN_EXP));
        @(negedge pclk);
        run_txn(3'b111, 2'b01, 6'o05, 16'h0000, 1'b0, L);
        lit("skpbz_skip", 32'(obs_skip[SKP_ACK]), 32'd0);

        @(negedge pclk);
        run_txn(3'b001, 2'b00, 6'o77, 16'h0000, 1'b0, L);
        lit("cpu_stb", 32'(obs_stb[1]), 32'd0);
        lit("cpu_ack_n1", 32'(obs_ack[1]), 32'd1);
        lit("cpu_rdata", 32'(obs_rdata[1]), 32'd0);

        @(negedge pclk);
        run_txn(3'b001, 2'b00, 6'o12, 16'h0000, 1'b1, L);
        lit("rst_busy", 32'(obs_busy[3]), 32'd0);
        lit("rst_stb", 32'(obs_stb[3]), 32'd0);
        lit("rst_ack", 32'(obs_ack[3]), 32'd0);
        @(negedge pclk);
        run_txn(3'b010, 2'b00, 6'o12, 16'h5A5A, 1'b0, L);
        lit("post_rst_doa_ack", 32'(obs_ack[2]), 32'd1);

        for (int n = 0; n < 300 && cyc < NC - 20; n++) begin
            repeat ($urandom_range(1, 3)) @(negedge pclk);
            x = 3'($urandom);
            c = 2'($urandom);
            d = ($urandom_range(0, 9) == 0) ? 6'o77 : 6'($urandom_range(1, 6));
            w = 16'($urandom);
            run_txn(x, c, d, w, 1'b0, L);
        end

        repeat (3) @(negedge pclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
